instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction-fetch stage of the 16-bit MIPS-style core. Drives PC, runs a req/ack handshake
//  with instruction memory, and presents one 16-bit instruction per cycle to decode/control.
//  Applies branch/jump redirects with in-flight discard. A 1-entry skid buffer absorbs decode stalls.
// PARAMETERS
//  PC_WIDTH  16     width of PC and memory address
//  PC_INC    2      PC increment per instruction (byte-addressed, 16-bit instr)
//  RESET_PC  0      first fetch address after reset
// PORTS
//  i_clk           in   1         clock, rising edge
//  i_rst_n         in   1         async reset, active low
//  o_imemReq       out  1         fetch request to instruction memory
//  o_imemAddr      out  PC_WIDTH  fetch address, stable while o_imemReq && !i_imemAck
//  i_imemAck       in   1         memory returns i_imemData this cycle
//  i_imemData      in   16        instruction word, valid when i_imemAck
//  i_stall         in   1         decode cannot accept; hold output
//  i_branchTaken   in   1         redirect to i_branchTarget (priority over jump)
//  i_branchTarget  in   PC_WIDTH  branch target address
//  i_jump          in   1         redirect to i_jumpTarget
//  i_jumpTarget    in   PC_WIDTH  jump target address
//  o_instrCode     out  16        instruction to decode/control
//  o_instrValid    out  1         o_instrCode valid
//  o_pcPlus        out  PC_WIDTH  address of o_instrCode + PC_INC
// BEHAVIOUR
//  Reset (async, i_rst_n=0): state=IDLE, fetchAddr=RESET_PC, o_imemReq=0, o_instrValid=0,
//   o_instrCode=16'h0000, o_pcPlus=0, skid empty.
//  States: IDLE, REQ, FULL, DROP. o_imemReq=1 in REQ and DROP, else 0. o_imemAddr=fetchAddr.
//  IDLE -> REQ unconditionally on the first edge after reset release.
//  Consume: cycle with o_instrValid && !i_stall. Output slot free = !o_instrValid || consume.
//  REQ, ack, no redirect: fetchAddr += PC_INC (mod 2^PC_WIDTH, wraps silently).
//   slot free: o_instrCode<=data, o_pcPlus<=fetchAddr+PC_INC, o_instrValid<=1; stay REQ.
//   slot not free: data+pcPlus into skid; -> FULL (request drops next cycle).
//  REQ, no ack: hold fetchAddr; if consume, o_instrValid<=0.
//  FULL: no requests. On consume, skid -> output (o_instrValid stays 1), skid empty, -> REQ.
//  Latency: ack in cycle N -> o_instrValid=1 in cycle N+1. With ack tied high and no stall:
//   1 instr/cycle, addresses RESET_PC, +2, +4, ...
//  Redirect = i_branchTaken || i_jump; target = branchTarget if i_branchTaken else jumpTarget.
//   Applied in any state except IDLE, regardless of i_stall (flush overrides stall):
//   o_instrValid<=0, skid cleared, ack data this cycle discarded.
//   REQ with no ack: pendPc<=target, -> DROP (o_imemAddr holds old address until ack).
//   REQ with ack, or FULL: fetchAddr<=target, -> REQ.
//   DROP: on ack discard data, fetchAddr<=pendPc, -> REQ. A newer redirect in DROP
//    overwrites pendPc, including one arriving with the ack (newest target wins).
//  o_instrCode/o_pcPlus hold their values while o_instrValid=0 (not cleared).
//  Reset mid-operation: immediate return to reset values; an outstanding memory request is
//   abandoned. Memory must accept req deassertion on reset.
//  Handshake rule: once o_imemReq=1, req and addr stay stable until i_imemAck (DROP enforces
//   this across redirects).
// TESTING
//  Reset, ack tied 1, no stall -> addr 0x0000,0x0002,0x0004; o_instrValid from cycle 2;
//   o_pcPlus 0x0002,0x0004.
//  2-cycle wait states (ack every 3rd cycle) -> addr held stable; one o_instrValid pulse per ack;
//   no duplicate or missing instrs.
//  i_stall=1 for 3 cycles while streaming -> o_instrCode frozen, skid fills, o_imemReq=0 in FULL;
//   after release, instrs arrive in order with none lost.
//  i_branchTaken with target 0x0040 while REQ pending at 0x0010, ack 2 cycles later ->
//   0x0010 data discarded; next addr 0x0040; first valid instr pcPlus=0x0042.
//  i_branchTaken and i_jump in same cycle (0x0080 vs 0x0100) -> fetch resumes at 0x0080;
//   jump in DROP then branch -> last target used.
//  PC at 0xFFFE, ack -> next addr 0x0000. Reset asserted mid-stall with skid full ->
//   all outputs at reset values; restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage with a req/ack memory handshake, redirect flush and a 1-entry skid buffer
//   i_clk/i_rst_n           clock (rising edge) and asynchronous active-low reset
//   o_imemReq/o_imemAddr    fetch request and address; both held stable until i_imemAck
//   i_imemAck/i_imemData    memory response; the data is valid only in the ack cycle
//   i_stall                 decode cannot take o_instrCode this cycle
//   i_branchTaken/Target    redirect; wins over a simultaneous jump
//   i_jump/i_jumpTarget     redirect
//   o_instrCode/Valid       instruction presented to decode
//   o_pcPlus                address of o_instrCode plus PC_INC
module instr_fetch #(
  parameter int                 PC_WIDTH = 16,
  parameter int                 PC_INC   = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_imemReq,
  output logic [PC_WIDTH-1:0] o_imemAddr,
  input  logic                i_imemAck,
  input  logic [15:0]         i_imemData,
  input  logic                i_stall,
  input  logic                i_branchTaken,
  input  logic [PC_WIDTH-1:0] i_branchTarget,
  input  logic                i_jump,
  input  logic [PC_WIDTH-1:0] i_jumpTarget,
  output logic [15:0]         o_instrCode,
  output logic                o_instrValid,
  output logic [PC_WIDTH-1:0] o_pcPlus
);
  typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [PC_WIDTH-1:0] pc_plus_q, pc_plus_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [15:0]         skid_instr_q, skid_instr_d;
  logic                valid_q, valid_d;
  logic                consume, slot_free, redirect;
  logic [PC_WIDTH-1:0] target, next_addr;

  assign consume    = valid_q && !i_stall;
  assign slot_free  = !valid_q || consume;
  assign redirect   = i_branchTaken || i_jump;
  assign target     = i_branchTaken ? i_branchTarget : i_jumpTarget;
  assign next_addr  = fetch_addr_q + PC_WIDTH'(PC_INC);
  assign o_imemReq  = (state_q == REQ) || (state_q == DROP);
  assign o_imemAddr = fetch_addr_q;
  assign o_instrCode  = instr_q;
  assign o_instrValid = valid_q;
  assign o_pcPlus     = pc_plus_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_pc_d    = pend_pc_q;
    pc_plus_d    = pc_plus_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    skid_instr_d = skid_instr_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (redirect) begin
          // An unanswered request cannot be withdrawn: park the target and wait out the ack.
          valid_d = 1'b0;
          if (i_imemAck) fetch_addr_d = target;
          else begin
            pend_pc_d = target;
            state_d   = DROP;
          end
        end else if (i_imemAck) begin
          fetch_addr_d = next_addr;
          if (slot_free) begin
            instr_d   = i_imemData;
            pc_plus_d = next_addr;
            valid_d   = 1'b1;
          end else begin
            skid_instr_d = i_imemData;
            skid_pc_d    = next_addr;
            state_d      = FULL;
          end
        end else if (consume) valid_d = 1'b0;
      end
      FULL: begin
        if (redirect) begin
          valid_d      = 1'b0;
          fetch_addr_d = target;
          state_d      = REQ;
        end else if (consume) begin
          instr_d   = skid_instr_q;
          pc_plus_d = skid_pc_q;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (redirect) begin
          valid_d   = 1'b0;
          pend_pc_d = target;
        end
        if (i_imemAck) begin
          fetch_addr_d = redirect ? target : pend_pc_q;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
      pend_pc_q    <= '0;
      pc_plus_q    <= '0;
      skid_pc_q    <= '0;
      instr_q      <= '0;
      skid_instr_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_pc_q    <= pend_pc_d;
      pc_plus_q    <= pc_plus_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      skid_instr_q <= skid_instr_d;
      valid_q      <= valid_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven bench for instr_fetch with an in-order instruction scoreboard
module tb_instr_fetch;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0, stall = 1'b0;
  logic        br = 1'b0, jp = 1'b0, instr_valid;
  logic [15:0] imem_addr, imem_data, bt = '0, jt = '0, instr_code, pc_plus;

  typedef struct {
    bit          ack, st, br;
    logic [15:0] bt;
    bit          jp;
    logic [15:0] jt;
    bit          req, vld;
  } vec_t;
  typedef struct {
    logic [15:0] code, pcp;
  } exp_t;

  vec_t        tbl[$];
  vec_t        post[$];
  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [15:0] exp_addr = '0, pend = '0;
  bit          drop = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  assign imem_data = imem_ack ? mem(imem_addr) : 16'hDEAD;

  instr_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imemReq(imem_req), .o_imemAddr(imem_addr),
    .i_imemAck(imem_ack), .i_imemData(imem_data),
    .i_stall(stall),
    .i_branchTaken(br), .i_branchTarget(bt),
    .i_jump(jp), .i_jumpTarget(jt),
    .o_instrCode(instr_code), .o_instrValid(instr_valid), .o_pcPlus(pc_plus)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input vec_t q[$], input bit ack, input bit st, input bit b, input logic [15:0] btv,
                     input bit j, input logic [15:0] jtv, input bit req, input bit vld, output vec_t r[$]);
    r = q;
    r.push_back('{ack, st, b, btv, j, jtv, req, vld});
  endtask

  task automatic row(input vec_t q[$], input bit ack, input bit st, input bit req, input bit vld, output vec_t r[$]);
    add(q, ack, st, 1'b0, 16'h0, 1'b0, 16'h0, req, vld, r);
  endtask

  task automatic run_row(input int idx, input vec_t v);
    logic [15:0] t;
    exp_t        e;
    imem_ack = v.ack; stall = v.st; br = v.br; bt = v.bt; jp = v.jp; jt = v.jt;
    @(negedge clk);
    chk($sformatf("req[%0d]", idx), {15'd0, imem_req}, {15'd0, v.req});
    chk($sformatf("valid[%0d]", idx), {15'd0, instr_valid}, {15'd0, v.vld});
    if (v.req) chk($sformatf("addr[%0d]", idx), imem_addr, exp_addr);
    if (v.vld && !v.st) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop[%0d]: got instr %h with no expected entry", idx, instr_code);
      end else begin
        e = sb.pop_front();
        chk($sformatf("code[%0d]", idx), instr_code, e.code);
        chk($sformatf("pcplus[%0d]", idx), pc_plus, e.pcp);
      end
    end
    t = v.br ? v.bt : v.jt;
    if (v.br || v.jp) begin
      sb.delete();
      if (drop) begin
        pend = t;
        if (v.ack) begin exp_addr = t; drop = 1'b0; end
      end else if (v.req && !v.ack) begin
        drop = 1'b1; pend = t;
      end else exp_addr = t;
    end else if (drop) begin
      if (v.ack) begin exp_addr = pend; drop = 1'b0; end
    end else if (v.req && v.ack) begin
      sb.push_back('{mem(exp_addr), 16'(exp_addr + 16'd2)});
      exp_addr = exp_addr + 16'd2;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ack, stall, req, vld: streaming, 3-cycle stall into the skid, then wait states
    row(tbl, 0, 0, 0, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 1, 1, 1, 1, tbl);
    row(tbl, 0, 1, 0, 1, tbl);
    row(tbl, 0, 1, 0, 1, tbl);
    row(tbl, 0, 0, 0, 1, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    row(tbl, 0, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    row(tbl, 0, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    // redirects: jump to 0x10 in flight, branch to 0x40 while 0x10 pending
    add(tbl, 0, 0, 0, 16'h0,   1, 16'h0010, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    add(tbl, 0, 0, 1, 16'h0040, 0, 16'h0,   1, 0, tbl);
    row(tbl, 0, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    // branch and jump together, then a chain of redirects while in DROP
    add(tbl, 1, 0, 1, 16'h0080, 1, 16'h0100, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    add(tbl, 0, 0, 0, 16'h0,   1, 16'h0200, 1, 1, tbl);
    add(tbl, 0, 0, 1, 16'h0300, 0, 16'h0,   1, 0, tbl);
    add(tbl, 1, 0, 0, 16'h0,   1, 16'h0400, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    // address wrap at 0xFFFE
    add(tbl, 1, 0, 0, 16'h0,   1, 16'hFFFE, 1, 0, tbl);
    row(tbl, 1, 0, 1, 0, tbl);
    row(tbl, 1, 0, 1, 1, tbl);
    row(tbl, 0, 0, 1, 1, tbl);
    // fill the skid under stall before the mid-run reset
    row(tbl, 1, 1, 1, 0, tbl);
    row(tbl, 1, 1, 1, 1, tbl);
    row(tbl, 0, 1, 0, 1, tbl);
    row(post, 0, 0, 0, 0, post);
    row(post, 1, 0, 1, 0, post);
    row(post, 0, 0, 1, 1, post);
    row(post, 0, 0, 1, 0, post);

    #12;
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_code", instr_code, 16'h0000);
    chk("rst_pcplus", pc_plus, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) run_row(i, tbl[i]);

    rst_n = 1'b0;
    imem_ack = 1'b0; stall = 1'b0; br = 1'b0; jp = 1'b0;
    #2;
    chk("mid_rst_req", {15'd0, imem_req}, 16'd0);
    chk("mid_rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    chk("mid_rst_code", instr_code, 16'h0000);
    chk("mid_rst_pcplus", pc_plus, 16'h0000);
    sb.delete();
    exp_addr = 16'h0000;
    drop = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < post.size(); i++) run_row(100 + i, post[i]);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
